// File: rtl/vu_pkg.sv
// Shared definitions for the VU meter bank: the meter mode encoding,
// the default parameter constants, and the mode-decode helper.
package vu_pkg;

  typedef enum logic [1:0] {
    VU_AVG  = 2'b00,
    VU_PEAK = 2'b01,
    VU_TEST = 2'b10
  } vu_mode_e;

  localparam int VU_NUM_CH     = 2;
  localparam int VU_SAMPLE_W   = 8;
  localparam int VU_AVG_LOG2   = 4;
  localparam int VU_PWM_BITS   = 7;
  localparam int VU_PWM_DIV    = 64;
  localparam int VU_DECAY_STEP = 1;

  // Code 2'b11 is not a real mode and falls back to averaging.
  function automatic vu_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return VU_PEAK;
      2'b10:   return VU_TEST;
      default: return VU_AVG;
    endcase
  endfunction

endpackage

// File: rtl/vu_meter_bank_if.sv
// Signal bundle for the VU meter bank pins.
//   master : drives samples/controls, observes meter outputs (stimulus side)
//   slave  : consumes samples/controls, drives meter outputs (meter side)
interface vu_meter_bank_if #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int PWM_BITS = 7
);
  logic [NUM_CH-1:0]          data_en;
  logic                       audio_enable;
  logic [NUM_CH*SAMPLE_W-1:0] audio_signal;
  logic [1:0]                 mode;
  logic [PWM_BITS-1:0]        test_level;
  logic                       invert_out;
  logic [NUM_CH-1:0]          vu_out;
  logic [NUM_CH*PWM_BITS-1:0] level_out;
  logic [NUM_CH-1:0]          level_valid;

  modport master (
    output data_en, audio_enable, audio_signal, mode, test_level, invert_out,
    input  vu_out, level_out, level_valid
  );

  modport slave (
    input  data_en, audio_enable, audio_signal, mode, test_level, invert_out,
    output vu_out, level_out, level_valid
  );
endinterface

// File: rtl/vu_channel.sv
// One meter channel: magnitude, frame accumulation and level ballistics.
//   clk, rst        : system clock, async active-high reset
//   audio_enable_i  : low clears the channel state and ignores strobes
//   data_en_i       : one-cycle sample strobe
//   sample_i        : signed sample
//   mode_i          : decoded meter mode
//   level_o         : displayed level
//   level_valid_o   : one-cycle pulse when level_o is updated
module vu_channel
  import vu_pkg::*;
#(
  parameter int SAMPLE_W   = VU_SAMPLE_W,
  parameter int AVG_LOG2   = VU_AVG_LOG2,
  parameter int PWM_BITS   = VU_PWM_BITS,
  parameter int DECAY_STEP = VU_DECAY_STEP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                audio_enable_i,
  input  logic                data_en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  vu_mode_e            mode_i,
  output logic [PWM_BITS-1:0] level_o,
  output logic                level_valid_o
);

  localparam int MAG_W = SAMPLE_W - 1;
  localparam int ACC_W = MAG_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [PWM_BITS:0] DECAY    = (PWM_BITS + 1)'(DECAY_STEP);

  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic                valid_q, valid_d;

  logic [SAMPLE_W-1:0] neg;
  logic [MAG_W-1:0]    mag;
  logic [ACC_W-1:0]    sum;
  logic [MAG_W-1:0]    avg;
  logic [PWM_BITS-1:0] new_lvl;
  logic [PWM_BITS-1:0] decayed;

  always_comb begin
    neg = '0 - sample_i;
    if (!sample_i[SAMPLE_W-1])
      mag = sample_i[MAG_W-1:0];
    else if (sample_i[MAG_W-1:0] == '0)
      mag = '1;                       // most negative code saturates
    else
      mag = neg[MAG_W-1:0];

    sum     = acc_q + ACC_W'(mag);    // sized for 2^AVG_LOG2 full-scale samples
    avg     = sum[ACC_W-1:AVG_LOG2];
    new_lvl = avg[MAG_W-1 -: PWM_BITS];

    if ({1'b0, level_q} > DECAY)
      decayed = level_q - DECAY[PWM_BITS-1:0];
    else
      decayed = '0;
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    valid_d = 1'b0;
    if (!audio_enable_i) begin
      acc_d   = '0;
      cnt_d   = '0;
      level_d = '0;
    end else if (data_en_i) begin
      if (cnt_q == CNT_LAST) begin
        acc_d = '0;
        cnt_d = '0;
        // Frames keep running in test mode but the level is frozen.
        if (mode_i != VU_TEST) begin
          valid_d = 1'b1;
          if (mode_i == VU_PEAK && new_lvl < level_q)
            level_d = decayed;
          else
            level_d = new_lvl;
        end
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  end

  assign level_o       = level_q;
  assign level_valid_o = valid_q;

endmodule

// File: rtl/vu_meter_bank.sv
// Bank of NUM_CH VU meters with shared PWM timebase.
//   clk, rst     : system clock, async active-high reset
//   data_en      : per-channel sample strobes
//   audio_enable : high while audio plays; low clears meter state
//   audio_signal : packed signed samples, channel 0 in the LSBs
//   mode         : 00 average, 01 peak-hold, 10 test, 11 average
//   test_level   : duty for all channels in test mode
//   invert_out   : invert the meter drive
//   vu_out       : registered PWM meter drive per channel
//   level_out    : packed displayed level per channel
//   level_valid  : per-channel level update pulse
module vu_meter_bank
  import vu_pkg::*;
#(
  parameter int NUM_CH     = VU_NUM_CH,
  parameter int SAMPLE_W   = VU_SAMPLE_W,
  parameter int AVG_LOG2   = VU_AVG_LOG2,
  parameter int PWM_BITS   = VU_PWM_BITS,
  parameter int PWM_DIV    = VU_PWM_DIV,
  parameter int DECAY_STEP = VU_DECAY_STEP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          data_en,
  input  logic                       audio_enable,
  input  logic [NUM_CH*SAMPLE_W-1:0] audio_signal,
  input  logic [1:0]                 mode,
  input  logic [PWM_BITS-1:0]        test_level,
  input  logic                       invert_out,
  output logic [NUM_CH-1:0]          vu_out,
  output logic [NUM_CH*PWM_BITS-1:0] level_out,
  output logic [NUM_CH-1:0]          level_valid
);

  if (PWM_BITS > SAMPLE_W - 1) begin : g_bad_param
    $error("vu_meter_bank: PWM_BITS must not exceed SAMPLE_W-1");
  end

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

  vu_mode_e mode_s;
  assign mode_s = decode_mode(mode);

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] step_q, step_d;
  logic                presc_wrap;
  logic                period_end;

  always_comb begin
    presc_wrap = (presc_q == PRE_LAST);
    period_end = presc_wrap && (step_q == '1);
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    step_d     = presc_wrap ? step_q + 1'b1 : step_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PWM_BITS-1:0] lvl;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                vu_q;

    vu_channel #(
      .SAMPLE_W  (SAMPLE_W),
      .AVG_LOG2  (AVG_LOG2),
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .audio_enable_i(audio_enable),
      .data_en_i     (data_en[c]),
      .sample_i      (audio_signal[c*SAMPLE_W +: SAMPLE_W]),
      .mode_i        (mode_s),
      .level_o       (lvl),
      .level_valid_o (level_valid[c])
    );

    // Duty is only reloaded as the step counter rolls over to 0.
    always_comb begin
      duty_d = duty_q;
      if (period_end)
        duty_d = (mode_s == VU_TEST) ? test_level : lvl;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_q <= '0;
        vu_q   <= 1'b0;
      end else begin
        duty_q <= duty_d;
        vu_q   <= (step_q < duty_q) ^ invert_out;
      end
    end

    assign vu_out[c]                       = vu_q;
    assign level_out[c*PWM_BITS +: PWM_BITS] = lvl;
  end

endmodule

// File: tb/tb_vu_meter_bank.sv
module tb_vu_meter_bank;
  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 8;
  localparam int PWM_BITS = 7;
  localparam int PERIOD   = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lv_seen = 0;

  vu_meter_bank_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PWM_BITS(PWM_BITS)) bus ();

  vu_meter_bank #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .AVG_LOG2(4),
    .PWM_BITS(PWM_BITS), .PWM_DIV(64), .DECAY_STEP(1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_en     (bus.data_en),
    .audio_enable(bus.audio_enable),
    .audio_signal(bus.audio_signal),
    .mode        (bus.mode),
    .test_level  (bus.test_level),
    .invert_out  (bus.invert_out),
    .vu_out      (bus.vu_out),
    .level_out   (bus.level_out),
    .level_valid (bus.level_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.level_valid != '0) lv_seen++;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [PWM_BITS-1:0] lvl(input int c);
    return bus.level_out[c*PWM_BITS +: PWM_BITS];
  endfunction

  task automatic send(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [1:0] en, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.data_en      = en;
      bus.audio_signal = {s1, s0};
    end
    @(posedge clk); #1;
    bus.data_en = '0;
  endtask

  task automatic count_high(output int h0, output int h1);
    h0 = 0; h1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(posedge clk); #1;
      if (bus.vu_out[0]) h0++;
      if (bus.vu_out[1]) h1++;
    end
  endtask

  task automatic test_reset;
    bus.data_en = '0; bus.audio_enable = 1'b0; bus.audio_signal = '0;
    bus.mode = 2'b00; bus.test_level = '0; bus.invert_out = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.vu_out !== 2'b00) begin errors++; $display("FAIL reset_vu: got %b want 00", bus.vu_out); end
    checks++; if (bus.level_out !== '0) begin errors++; $display("FAIL reset_level: got %h want 0", bus.level_out); end
    checks++; if (bus.level_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", bus.level_valid); end
    rst = 1'b0;
    @(posedge clk); #1;
    bus.audio_enable = 1'b1;
  endtask

  task automatic test_average;
    int h0, h1;
    send(8'd64, 8'd0, 2'b01, 15);
    checks++; if (bus.level_valid !== 2'b00) begin errors++; $display("FAIL avg_early_valid: got %b want 00", bus.level_valid); end
    send(8'd64, 8'd0, 2'b01, 1);
    checks++; if (bus.level_valid !== 2'b01) begin errors++; $display("FAIL avg_valid: got %b want 01", bus.level_valid); end
    checks++; if (lvl(0) !== 7'd64) begin errors++; $display("FAIL avg_level: got %0d want 64", lvl(0)); end
    @(posedge clk); #1;
    checks++; if (bus.level_valid !== 2'b00) begin errors++; $display("FAIL avg_valid_pulse: got %b want 00", bus.level_valid); end
    repeat (PERIOD + 8) @(posedge clk);
    count_high(h0, h1);
    checks++; if (h0 != 4096) begin errors++; $display("FAIL avg_pwm_high: got %0d want 4096", h0); end
  endtask

  task automatic test_saturate;
    int h0, h1;
    send(8'h80, 8'd0, 2'b01, 16);
    checks++; if (lvl(0) !== 7'd127) begin errors++; $display("FAIL sat_level: got %0d want 127", lvl(0)); end
    repeat (PERIOD + 8) @(posedge clk);
    count_high(h0, h1);
    checks++; if (PERIOD - h0 != 64) begin errors++; $display("FAIL sat_pwm_low: got %0d want 64", PERIOD - h0); end
  endtask

  task automatic test_dual;
    send(8'd32, 8'hB0, 2'b11, 16);  // ch1 = -80
    checks++; if (bus.level_valid !== 2'b11) begin errors++; $display("FAIL dual_valid: got %b want 11", bus.level_valid); end
    checks++; if (lvl(0) !== 7'd32) begin errors++; $display("FAIL dual_level0: got %0d want 32", lvl(0)); end
    checks++; if (lvl(1) !== 7'd80) begin errors++; $display("FAIL dual_level1: got %0d want 80", lvl(1)); end
  endtask

  task automatic test_peak;
    logic [7:0] samp [6] = '{8'd100, 8'd0, 8'd0, 8'd0, 8'd120, 8'd0};
    logic [6:0] want [6] = '{7'd100, 7'd99, 7'd98, 7'd97, 7'd120, 7'd119};
    bus.audio_enable = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.level_out !== '0) begin errors++; $display("FAIL peak_clear: got %h want 0", bus.level_out); end
    bus.audio_enable = 1'b1;
    bus.mode = 2'b01;
    for (int f = 0; f < 6; f++) begin
      send(samp[f], 8'd0, 2'b01, 16);
      checks++;
      if (lvl(0) !== want[f]) begin
        errors++; $display("FAIL peak_frame%0d: got %0d want %0d", f, lvl(0), want[f]);
      end
    end
    bus.mode = 2'b00;
  endtask

  task automatic test_disable;
    send(8'd127, 8'd0, 2'b01, 7);
    bus.audio_enable = 1'b0;
    @(posedge clk); #1;
    checks++; if (lvl(0) !== 7'd0) begin errors++; $display("FAIL dis_clear: got %0d want 0", lvl(0)); end
    send(8'd127, 8'd0, 2'b01, 4);
    checks++; if (bus.level_valid !== 2'b00 || lvl(0) !== 7'd0) begin
      errors++; $display("FAIL dis_ignore: got valid=%b level=%0d want 00/0", bus.level_valid, lvl(0));
    end
    bus.audio_enable = 1'b1;
    send(8'd16, 8'd0, 2'b01, 15);
    checks++; if (bus.level_valid !== 2'b00) begin errors++; $display("FAIL dis_residue_valid: got %b want 00", bus.level_valid); end
    send(8'd16, 8'd0, 2'b01, 1);
    checks++; if (lvl(0) !== 7'd16) begin errors++; $display("FAIL dis_level: got %0d want 16", lvl(0)); end
  endtask

  task automatic test_test_mode;
    int h0, h1;
    bus.mode = 2'b10; bus.test_level = 7'd32; bus.invert_out = 1'b1;
    @(posedge clk); #1;
    lv_seen = 0;
    send(8'd90, 8'd90, 2'b11, 16);
    repeat (PERIOD + 8) @(posedge clk);
    count_high(h0, h1);
    checks++; if (h0 != 6144) begin errors++; $display("FAIL test_ch0_high: got %0d want 6144", h0); end
    checks++; if (h1 != 6144) begin errors++; $display("FAIL test_ch1_high: got %0d want 6144", h1); end
    checks++; if (lv_seen != 0) begin errors++; $display("FAIL test_valid_silent: got %0d pulses want 0", lv_seen); end
    checks++; if (lvl(0) !== 7'd16) begin errors++; $display("FAIL test_level_hold: got %0d want 16", lvl(0)); end
    bus.mode = 2'b00; bus.invert_out = 1'b0;
  endtask

  task automatic test_reset_async;
    int  n = 0;
    send(8'd127, 8'd100, 2'b11, 16);
    while (bus.vu_out[0] !== 1'b1 && n < 2 * PERIOD) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (bus.vu_out[0] !== 1'b1) begin errors++; $display("FAIL rst_wait_high: got %b want 1", bus.vu_out[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.vu_out !== 2'b00) begin errors++; $display("FAIL rst_async_vu: got %b want 00", bus.vu_out); end
    checks++; if (bus.level_out !== '0) begin errors++; $display("FAIL rst_async_level: got %h want 0", bus.level_out); end
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.level_out !== '0 || bus.vu_out !== 2'b00) begin
      errors++; $display("FAIL rst_release: got level=%h vu=%b want 0/00", bus.level_out, bus.vu_out);
    end
  endtask

  initial begin
    test_reset;
    test_average;
    test_saturate;
    test_dual;
    test_peak;
    test_disable;
    test_test_mode;
    test_reset_async;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vu_meter_bank.md
VU_METER_BANK -- requirements
Module: vu_meter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independent meter channels.
REQ-002 SHALL have parameter SAMPLE_W, default 8: signed two's-complement sample width.
REQ-003 SHALL have parameter AVG_LOG2, default 4: log2 of samples averaged per frame (16).
REQ-004 SHALL have parameter PWM_BITS, default 7: duty resolution, 2^PWM_BITS steps; legal only when PWM_BITS <= SAMPLE_W-1.
REQ-005 SHALL have parameter PWM_DIV, default 64: clk cycles per PWM step.
REQ-006 SHALL have parameter DECAY_STEP, default 1: peak-hold decay in level LSBs per frame.
REQ-007 SHALL have port clk, input, 1: single system clock.
REQ-008 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-009 SHALL have port data_en, input, NUM_CH: per-channel one-cycle sample strobe.
REQ-010 SHALL have port audio_enable, input, 1: high while audio is playing.
REQ-011 SHALL have port audio_signal, input, NUM_CH*SAMPLE_W: packed samples, channel 0 in the LSBs.
REQ-012 SHALL have port mode, input, 2: 00 average, 01 peak-hold, 10 test, 11 treated as 00.
REQ-013 SHALL have port test_level, input, PWM_BITS: duty applied to all channels in test mode.
REQ-014 SHALL have port invert_out, input, 1: when high, vu_out is inverted (active-low meter drive).
REQ-015 SHALL have port vu_out, output, NUM_CH: PWM meter drive.
REQ-016 SHALL have port level_out, output, NUM_CH*PWM_BITS: current displayed level per channel.
REQ-017 SHALL have port level_valid, output, NUM_CH: one-cycle pulse when that channel's level_out updates.

Function
REQ-018 Each sample SHALL be converted to magnitude |x|, with the most negative code saturating to 2^(SAMPLE_W-1)-1 (-128 -> 127).
REQ-019 On data_en[c] with audio_enable high, the channel SHALL add the magnitude to an accumulator of width SAMPLE_W-1+AVG_LOG2 and increment a sample counter modulo 2^AVG_LOG2; the accumulator cannot overflow.
REQ-020 On the strobe that completes the 2^AVG_LOG2-th sample, the channel SHALL compute avg = (acc+mag)>>AVG_LOG2, take its top PWM_BITS bits as new_lvl, and reload the accumulator to 0 in the same cycle.
REQ-021 In average mode, level SHALL be set to new_lvl; in peak mode, level SHALL be set to new_lvl if new_lvl >= level, else to level-DECAY_STEP, saturating at 0.
REQ-022 level_out[c] and level_valid[c] SHALL assert exactly 1 clk after the completing data_en[c]; level_valid stays low in test mode.
REQ-023 A shared prescaler SHALL count 0..PWM_DIV-1, and a shared step counter SHALL count 0..2^PWM_BITS-1, advancing on each prescaler wrap; both run freely.
REQ-024 Each channel SHALL latch its duty (level_out, or test_level in test mode) only when the step counter wraps to 0, so no partial PWM period is produced.
REQ-025 The raw PWM SHALL be high while step < duty: duty 0 is constantly low, and full scale gives (2^PWM_BITS-1)/2^PWM_BITS high time.
REQ-026 vu_out SHALL be registered, equal to raw PWM XOR invert_out.
REQ-027 While audio_enable is low, accumulators, sample counters and levels SHALL clear synchronously to 0, data_en SHALL be ignored, and the PWM counters SHALL continue.
REQ-028 A mode change SHALL take effect at the next frame or PWM wrap, with no counter reset; switching into peak mode starts from the current level.
REQ-029 Strobes on different channels in the same cycle SHALL be processed independently.

Reset
REQ-030 rst SHALL asynchronously clear all counters, accumulators, levels, latched duties and level_valid to 0, and set vu_out to invert_out's reset-neutral value 0 (raw low); on release, operation resumes from the count origin.

Structure
REQ-031 Package vu_pkg SHALL hold the mode enum (VU_AVG, VU_PEAK, VU_TEST) and the default parameter constants.
REQ-032 Per-channel envelope, accumulate and ballistics logic SHALL be sub-module vu_channel, instantiated NUM_CH times by generate; the PWM counters are shared in the top level.

Verification
REQ-033 Average mode, ch0 fed 16 samples of +64 -> level_out[6:0]=64 and level_valid one clk after the 16th strobe; vu_out high 64 of 128 steps (4096 clks of 8192).
REQ-034 Feed 16 samples of -128 -> magnitude saturates at 127, level=127, vu_out low for exactly 1 step (64 clks) per period.
REQ-035 Peak mode, DECAY_STEP=1: one frame at 100 then frames at 0 -> level 100, 99, 98, ...; a new frame at 120 jumps to 120.
REQ-036 Test mode, test_level=32, invert_out=1 -> both vu_out low 2048 clks and high 6144 clks per 8192, level_valid silent.
REQ-037 Drop audio_enable mid-frame after 7 samples, then re-enable and send 16 samples of +16 -> level=16, with no residue from the aborted frame.
REQ-038 Assert rst mid-PWM-high -> vu_out goes to its idle state immediately (asynchronous), and all levels read 0 after release.
